// File: rtl/autosa_out_round_sat_pipe.sv
// -----------------------------------------------------------------------------
// autosa_out_round_sat_pipe
//
// Purpose: rounds the output of the unsigned shift-right-with-saturation stage
// (integer part plus fraction bits) using a configurable rounding mode. It then
// narrows the result to OUT_WIDTH with unsigned saturation. This is a two-stage
// valid/ready pipeline that sustains one transfer per cycle. A sticky
// saturation-event counter is provided for performance monitoring.
//
// Ports:
//   autosa_core_clk   core clock
//   autosa_core_rstn  asynchronous active-low reset
//   in_pvld/in_prdy   input handshake
//   in_data           shifted integer part (unsigned, IN_WIDTH)
//   in_frac           fraction bits, MSB weighs 0.5 (FRAC_WIDTH)
//   cfg_rnd_mode      0 truncate, 1 half-up, 2 half-even, 3 truncate
//   cfg_cnt_clr       synchronous clear of sat_cnt (wins over increment)
//   out_pvld/out_prdy output handshake
//   out_data          rounded, saturated result (OUT_WIDTH)
//   out_sat           this output saturated
//   sat_cnt           saturated outputs transferred, sticks at all ones
// -----------------------------------------------------------------------------
module autosa_out_round_sat_pipe #(
    parameter int IN_WIDTH   = 32,
    parameter int FRAC_WIDTH = 35,
    parameter int OUT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  autosa_core_clk,
    input  logic                  autosa_core_rstn,
    input  logic                  in_pvld,
    output logic                  in_prdy,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic [FRAC_WIDTH-1:0] in_frac,
    input  logic [1:0]            cfg_rnd_mode,
    input  logic                  cfg_cnt_clr,
    output logic                  out_pvld,
    input  logic                  out_prdy,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [CNT_WIDTH-1:0]  sat_cnt
);

    // Rounded sum is one bit wider than the input, so the increment never wraps.
    function automatic logic [IN_WIDTH:0] round_sum(
        input logic [IN_WIDTH-1:0]   data,
        input logic [FRAC_WIDTH-1:0] frac,
        input logic [1:0]            mode
    );
        logic half;
        logic sticky;
        logic inc;
        half   = frac[FRAC_WIDTH-1];
        sticky = |frac[FRAC_WIDTH-2:0];
        case (mode)
            2'd1:    inc = half;
            2'd2:    inc = half & (sticky | data[0]);
            default: inc = 1'b0;
        endcase
        return {1'b0, data} + {{IN_WIDTH{1'b0}}, inc};
    endfunction

    // Returns {sat, narrowed_data}.
    function automatic logic [OUT_WIDTH:0] sat_narrow(input logic [IN_WIDTH:0] sum);
        logic sat;
        sat = |sum[IN_WIDTH:OUT_WIDTH];
        return sat ? {1'b1, {OUT_WIDTH{1'b1}}} : {1'b0, sum[OUT_WIDTH-1:0]};
    endfunction

    logic                 vld_p1_q, vld_p1_d;
    logic [IN_WIDTH:0]    sum_p1_q, sum_p1_d;
    logic                 vld_p2_q, vld_p2_d;
    logic [OUT_WIDTH-1:0] data_p2_q, data_p2_d;
    logic                 sat_p2_q, sat_p2_d;
    logic [CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
    logic                 adv_p1, adv_p2;
    logic                 sat_xfer;

    assign adv_p2   = !vld_p2_q || out_prdy;
    assign adv_p1   = !vld_p1_q || adv_p2;
    assign in_prdy  = adv_p1;
    assign out_pvld = vld_p2_q;
    assign out_data = data_p2_q;
    assign out_sat  = sat_p2_q;
    assign sat_cnt  = sat_cnt_q;
    assign sat_xfer = vld_p2_q && out_prdy && sat_p2_q;

    always_comb begin
        vld_p1_d  = vld_p1_q;
        sum_p1_d  = sum_p1_q;
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        sat_p2_d  = sat_p2_q;
        sat_cnt_d = sat_cnt_q;

        // Stage 1: round on input transfer; the mode is sampled only here.
        if (adv_p1) begin
            vld_p1_d = in_pvld;
            if (in_pvld) begin
                sum_p1_d = round_sum(in_data, in_frac, cfg_rnd_mode);
            end
        end

        // Stage 2: saturate and narrow; a draining stage refills on the same edge.
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                {sat_p2_d, data_p2_d} = sat_narrow(sum_p1_q);
            end
        end

        if (cfg_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (sat_xfer && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            vld_p1_q  <= 1'b0;
            sum_p1_q  <= '0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            sat_p2_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            sum_p1_q  <= sum_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            sat_p2_q  <= sat_p2_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_autosa_out_round_sat_pipe.sv
module tb_autosa_out_round_sat_pipe;

    localparam int IW = 32;
    localparam int FW = 35;
    localparam int OW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_pvld;
    logic          in_prdy;
    logic [IW-1:0] in_data;
    logic [FW-1:0] in_frac;
    logic [1:0]    cfg_rnd_mode;
    logic          cfg_cnt_clr;
    logic          out_pvld;
    logic          out_prdy;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic [CW-1:0] sat_cnt;

    typedef struct {
        logic [OW-1:0] data;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_acc  = 0;
    logic [CW-1:0] cnt_exp = '0;

    always #5 clk = ~clk;

    autosa_out_round_sat_pipe #(
        .IN_WIDTH(IW), .FRAC_WIDTH(FW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
    ) dut (
        .autosa_core_clk (clk),
        .autosa_core_rstn(rstn),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_data         (in_data),
        .in_frac         (in_frac),
        .cfg_rnd_mode    (cfg_rnd_mode),
        .cfg_cnt_clr     (cfg_cnt_clr),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_data        (out_data),
        .out_sat         (out_sat),
        .sat_cnt         (sat_cnt)
    );

    // Reference: exact arithmetic on the real value data + frac/2^35.
    function automatic exp_t model(input logic [IW-1:0] d, input logic [FW-1:0] f,
                                   input logic [1:0] m);
        exp_t r;
        longint unsigned ff, v;
        bit half, rest_nz, up;
        ff      = 64'(f);
        half    = ff >= 64'h4_0000_0000;
        rest_nz = (ff % 64'h4_0000_0000) != 0;
        case (m)
            2'd1:    up = half;
            2'd2:    up = half && (rest_nz || (d % 2 == 1));
            default: up = 1'b0;
        endcase
        v = 64'(d) + (up ? 64'd1 : 64'd0);
        if (v > 64'd65535) begin
            r.data = 16'hFFFF;
            r.sat  = 1'b1;
        end else begin
            r.data = v[OW-1:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [IW-1:0] d, input logic [FW-1:0] f, input logic [1:0] m);
        bit ok;
        in_pvld      = 1'b1;
        in_data      = d;
        in_frac      = f;
        cfg_rnd_mode = m;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            ok = in_prdy;
            @(posedge clk);
            #1;
            if (ok) begin
                sb.push_back(model(d, f, m));
                n_acc++;
                return;
            end
        end
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_pvld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Pops expected words on every output transfer and tracks the counter.
    task automatic monitor();
        exp_t          e;
        bit            hold_v = 1'b0;
        logic [OW-1:0] hold_d = '0;
        logic          hold_s = 1'b0;
        bit            xsat;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sb.delete();
                cnt_exp = '0;
                hold_v  = 1'b0;
            end else begin
                chk("sat_cnt", 64'(sat_cnt), 64'(cnt_exp));
                if (hold_v) begin
                    chk("stall_pvld", 64'(out_pvld), 64'd1);
                    chk("stall_data", 64'(out_data), 64'(hold_d));
                    chk("stall_sat", 64'(out_sat), 64'(hold_s));
                end
                xsat = 1'b0;
                if (out_pvld && out_prdy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'(out_data), 64'(e.data));
                        chk("out_sat", 64'(out_sat), 64'(e.sat));
                        xsat = e.sat;
                    end
                end
                if (cfg_cnt_clr) cnt_exp = '0;
                else if (xsat && cnt_exp != '1) cnt_exp = cnt_exp + 1'b1;
                hold_v = out_pvld && !out_prdy;
                hold_d = out_data;
                hold_s = out_sat;
            end
        end
    endtask

    task automatic latency_check(input string name);
        @(negedge clk);
        chk({name, "_pvld_c1"}, 64'(out_pvld), 64'd0);
        @(negedge clk);
        chk({name, "_pvld_c2"}, 64'(out_pvld), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        logic [IW-1:0] d;
        logic [FW-1:0] f;

        rstn = 1'b0; in_pvld = 1'b0; in_data = '0; in_frac = '0;
        cfg_rnd_mode = 2'd0; cfg_cnt_clr = 1'b0; out_prdy = 1'b1;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pvld", 64'(out_pvld), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sat", 64'(out_sat), 64'd0);
        chk("rst_cnt", 64'(sat_cnt), 64'd0);
        chk("rst_prdy", 64'(in_prdy), 64'd1);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Directed: truncate with latency, then rounding modes and saturation.
        send(32'h1234, 35'h7FFFFFFFF, 2'd0);
        idle();
        latency_check("trunc");
        send(32'h1234, 35'h400000000, 2'd1);
        send(32'h1234, 35'h3FFFFFFFF, 2'd1);
        send(32'h0002, 35'h400000000, 2'd2);
        send(32'h0003, 35'h400000000, 2'd2);
        send(32'h0002, 35'h400000001, 2'd2);
        send(32'h00010000, 35'h0, 2'd0);
        send(32'h0000FFFF, 35'h400000000, 2'd1);
        idle();
        drain();
        chk("cnt_after_two", 64'(sat_cnt), 64'd2);

        // Clear coincident with a third saturated transfer.
        send(32'h00020000, 35'h0, 2'd0);
        idle();
        @(posedge clk); #1 cfg_cnt_clr = 1'b1;
        @(posedge clk); #1 cfg_cnt_clr = 1'b0;
        chk("cnt_clr_prio", 64'(sat_cnt), 64'd0);
        chk("clr_word_out", 64'(sb.size()), 64'd0);

        // Counter sticks at all ones.
        for (int i = 0; i < 17; i++) send(32'h80000000 | $urandom, 35'h0, 2'd0);
        idle();
        drain();
        chk("cnt_stick", 64'(sat_cnt), 64'd15);

        // Backpressure: two accepts then stall, release with no gaps.
        out_prdy = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 35'h0, 2'd0);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_accepts", 64'(n_acc), 64'd2);
                chk("bp_in_prdy", 64'(in_prdy), 64'd0);
                @(posedge clk); #1 out_prdy = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_no_gap", 64'(out_pvld), 64'd1);
                end
                @(posedge clk); #1;
            end
        join
        drain();

        // Reset mid-stream with both stages full and counter nonzero.
        out_prdy = 1'b0;
        send(32'h0000AAAA, 35'h0, 2'd0);
        send(32'h0000BBBB, 35'h0, 2'd0);
        idle();
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_pvld", 64'(out_pvld), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_cnt", 64'(sat_cnt), 64'd0);
        out_prdy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_pvld", 64'(out_pvld), 64'd0);
        chk("post_rst_prdy", 64'(in_prdy), 64'd1);
        send(32'h0000CAFE, 35'h400000000, 2'd1);
        idle();
        latency_check("post_rst");
        drain();

        // Randomized traffic with random backpressure and counter clears.
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    case ($urandom_range(0, 2))
                        0:       d = 32'($urandom_range(0, 16'hFFFF));
                        1:       d = 32'($urandom_range(32'hFFF0, 32'h1000F));
                        default: d = $urandom;
                    endcase
                    case ($urandom_range(0, 3))
                        0:       f = 35'h400000000;
                        1:       f = 35'h0;
                        2:       f = 35'h400000000 | 35'($urandom_range(0, 3));
                        default: f = {$urandom_range(0, 7), $urandom};
                    endcase
                    send(d, f, 2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk); #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_prdy    = $urandom_range(0, 3) != 0;
                    cfg_cnt_clr = $urandom_range(0, 31) == 0;
                end
                out_prdy    = 1'b1;
                cfg_cnt_clr = 1'b0;
            end
        join
        drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/autosa_out_round_sat_pipe.md
Name: autosa_out_round_sat_pipe

Overview:
Downstream consumer of the unsigned shift-right-with-saturation stage in the AUTOSA output-conversion path. Takes the shifted integer part and its fraction bits, applies a configurable rounding mode, and narrows the result to OUT_WIDTH with unsigned saturation. Two-stage valid/ready pipeline that sustains one transfer per cycle; a saturating event counter supports performance monitoring.

Parameters:
IN_WIDTH, 32, width of the shifted integer input (matches shifter OUT_WIDTH)
FRAC_WIDTH, 35, width of the fraction input (matches shifter FRAC_WIDTH)
OUT_WIDTH, 16, width of the narrowed output; OUT_WIDTH < IN_WIDTH
CNT_WIDTH, 32, width of the saturation event counter

Ports:
autosa_core_clk  input  1  core clock
autosa_core_rstn  input  1  reset, asynchronous, active-low
in_pvld  input  1  input valid
in_prdy  output  1  input ready
in_data  input  IN_WIDTH  shifted integer part, unsigned
in_frac  input  FRAC_WIDTH  fraction bits; MSB has weight 0.5
cfg_rnd_mode  input  2  0 truncate, 1 round-half-up, 2 round-half-even, 3 reserved (behaves as truncate)
cfg_cnt_clr  input  1  synchronous clear of sat_cnt
out_pvld  output  1  output valid
out_prdy  input  1  output ready
out_data  output  OUT_WIDTH  rounded, saturated result
out_sat  output  1  this output saturated
sat_cnt  output  CNT_WIDTH  count of transferred saturated outputs

Behaviour:
- Reset (async assert, sync deassert): s1_vld=0, s2_vld=0, out_pvld=0, out_data=0, out_sat=0, sat_cnt=0. Payload registers are also cleared.
- Clock and reset are fixed: single clock autosa_core_clk; autosa_core_rstn is asynchronous, active-low.
- Transfer rule: a transfer occurs on a rising edge with valid&ready both high. in_pvld and in_data/in_frac are held stable by the source while in_prdy=0.
- Stage 1 captures on input transfer. cfg_rnd_mode is sampled at this point and is not re-read later.
- Half-bit h = in_frac[FRAC_WIDTH-1]. Sticky bit s = |in_frac[FRAC_WIDTH-2:0].
- Increment inc:
  - mode 0/3: inc=0
  - mode 1: inc=h
  - mode 2: inc=h&(s|in_data[0])
- Stage 1 stores sum = {1'b0,in_data} + inc, IN_WIDTH+1 bits. No wrap is possible.
- Stage 2 computes the saturate flag: sat = |sum[IN_WIDTH:OUT_WIDTH].
  - If sat=1: out_data = all ones.
  - Else: out_data = sum[OUT_WIDTH-1:0].
  - out_sat = sat.
- Pipeline control:
  - s2 advance condition: s2_adv = !s2_vld | out_prdy.
  - s1 advance condition: s1_adv = !s1_vld | s2_adv.
  - in_prdy = s1_adv, combinational and free of combinational dependence on in_pvld.
  - out_pvld = s2_vld.
- Latency: 2 cycles from input transfer to out_pvld with no backpressure. Throughput is 1/cycle.
- Backpressure: while out_prdy=0 and both stages are full, in_prdy=0. No data is dropped or duplicated, and order is preserved. out_data/out_sat stay stable while out_pvld=1 and out_prdy=0.
- Simultaneous events: when a stage both drains and refills on the same edge, the new data is loaded.
- sat_cnt:
  - Increments by 1 on each output transfer with out_sat=1.
  - Sticks at all ones and does not wrap.
  - cfg_cnt_clr=1 forces 0 on the next edge and takes priority over a coincident increment.
- Reset mid-operation: all in-flight data is discarded. After deassert, out_pvld=0 and in_prdy=1 until new input arrives.

Test Plan:
- Truncate: mode0, in_data=0x00001234, in_frac=0x7FFFFFFFF -> out_data=0x1234, out_sat=0, out_pvld 2 cycles after accept.
- Half-up: mode1, in_data=0x00001234, in_frac=0x400000000 -> 0x1235. Same data with in_frac=0x3FFFFFFFF -> 0x1234.
- Half-even ties: mode2, in_frac=0x400000000:
  - in_data=0x0002 -> 0x0002
  - in_data=0x0003 -> 0x0004
  - in_data=0x0002 with in_frac=0x400000001 -> 0x0003
- Saturation and counter:
  - in_data=0x00010000 mode0 -> out_data=0xFFFF, out_sat=1.
  - in_data=0x0000FFFF mode1 with h=1 -> 0xFFFF, out_sat=1, sat_cnt=2.
  - cfg_cnt_clr pulsed coincident with a third saturated transfer -> sat_cnt=0.
- Backpressure: stream 4 words back-to-back, hold out_prdy=0 for 5 cycles -> in_prdy=0 after 2 accepts; release -> all 4 emerge in order, values unchanged, no gaps when out_prdy=1.
- Reset mid-stream: assert autosa_core_rstn=0 with both stages full -> out_pvld=0, out_data=0, sat_cnt=0 immediately (async). After release, in_prdy=1 and the first new word appears 2 cycles after accept.
